// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
//   Buffers execute-stage results in a small FIFO and drains them one per
//   cycle into the register-file write port. It holds off while the register
//   file reports busy. Entries whose destination index is above 5 are dropped,
//   and bad_dest pulses for one cycle when that happens. pend_e/pend_v show
//   which registers still have a write queued or on the write port.
//
// Parameters
//   DEPTH      number of FIFO entries (power of two, 2..16)
//
// Configuration
//   WB_FORWARD_EN  when defined, the fwd_* lookup returns the newest queued
//                  value for a register; otherwise fwd_hit/fwd_e/fwd_v are 0.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   wb_valid/wb_ready            result handshake from execute
//   wb_type, wb_dest             destination type (0 scalar, 1 vector), index
//   wb_scalar, wb_vector         result data (21 / 192 bits)
//   rf_busy                      register file cannot accept a write
//   Reg_write, A3, desType       register-file write strobe, index, type
//   wd3e, wd3v                   scalar / vector write data
//   pend_e, pend_v               registers with outstanding writes
//   bad_dest                     pulse: an entry with an illegal index was dropped
//   fwd_type, fwd_addr           forwarding lookup key
//   fwd_hit, fwd_e, fwd_v        forwarding result
// ---------------------------------------------------------------------------
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic         wb_type,
  input  logic [2:0]   wb_dest,
  input  logic [20:0]  wb_scalar,
  input  logic [191:0] wb_vector,
  input  logic         rf_busy,
  output logic         Reg_write,
  output logic [2:0]   A3,
  output logic         desType,
  output logic [20:0]  wd3e,
  output logic [191:0] wd3v,
  output logic [5:0]   pend_e,
  output logic [5:0]   pend_v,
  output logic         bad_dest,
  input  logic         fwd_type,
  input  logic [2:0]   fwd_addr,
  output logic         fwd_hit,
  output logic [20:0]  fwd_e,
  output logic [191:0] fwd_v
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, STALL} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               bad_dest_q;
  logic [2:0]         a3_q;
  logic               des_type_q;
  logic [20:0]        wd3e_q;
  logic [191:0]       wd3v_q;

  // Scalar entries are stored zero-extended in the shared data word.
  logic               type_mem [DEPTH];
  logic [2:0]         dest_mem [DEPTH];
  logic [191:0]       data_mem [DEPTH];

  logic accept, push, pop;

  // Readiness uses the registered count only, so a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign wb_ready = (count_q < CNT_W'(DEPTH));
  assign accept   = wb_valid && wb_ready;
  assign push     = accept && (wb_dest <= 3'd5);
  assign pop      = (count_q != '0) && !rf_busy;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // NOTE: FIFO storage has no reset; occupancy is tracked by count/pointers,
  // so stale slots are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr_q] <= wb_type;
      dest_mem[wr_ptr_q] <= wb_dest;
      data_mem[wr_ptr_q] <= wb_type ? wb_vector : {171'd0, wb_scalar};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bad_dest_q <= 1'b0;
      a3_q       <= '0;
      des_type_q <= 1'b0;
      wd3e_q     <= '0;
      wd3v_q     <= '0;
    end else begin
      bad_dest_q <= accept && (wb_dest > 3'd5);
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        state_q    <= WRITE;
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        a3_q       <= dest_mem[rd_ptr_q];
        des_type_q <= type_mem[rd_ptr_q];
        wd3e_q     <= type_mem[rd_ptr_q] ? 21'd0 : data_mem[rd_ptr_q][20:0];
        wd3v_q     <= type_mem[rd_ptr_q] ? data_mem[rd_ptr_q] : 192'd0;
      end else begin
        state_q    <= (count_q != '0) ? STALL : IDLE;
        a3_q       <= '0;
        des_type_q <= 1'b0;
        wd3e_q     <= '0;
        wd3v_q     <= '0;
      end
    end
  end

  assign Reg_write = (state_q == WRITE);
  assign A3        = a3_q;
  assign desType   = des_type_q;
  assign wd3e      = wd3e_q;
  assign wd3v      = wd3v_q;
  assign bad_dest  = bad_dest_q;

  // Pending bitmaps: every occupied FIFO slot plus the entry on the write port.
  always_comb begin
    logic [PTR_W-1:0] idx;
    pend_e = '0;
    pend_v = '0;
    idx    = '0;
    for (int r = 0; r < 6; r++) begin
      if (Reg_write && a3_q == 3'(r)) begin
        if (des_type_q) pend_v[r] = 1'b1;
        else            pend_e[r] = 1'b1;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        idx = rd_ptr_q + PTR_W'(k);
        for (int r = 0; r < 6; r++) begin
          if (dest_mem[idx] == 3'(r)) begin
            if (type_mem[idx]) pend_v[r] = 1'b1;
            else               pend_e[r] = 1'b1;
          end
        end
      end
    end
  end

`ifdef WB_FORWARD_EN
  // Oldest candidate (write port) is checked first, then the FIFO from head
  // to tail, so the last match written is the newest value.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit = 1'b0;
    fwd_e   = '0;
    fwd_v   = '0;
    idx     = '0;
    if (Reg_write && des_type_q == fwd_type && a3_q == fwd_addr) begin
      fwd_hit = 1'b1;
      fwd_e   = wd3e_q;
      fwd_v   = wd3v_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        idx = rd_ptr_q + PTR_W'(k);
        if (type_mem[idx] == fwd_type && dest_mem[idx] == fwd_addr) begin
          fwd_hit = 1'b1;
          fwd_e   = type_mem[idx] ? 21'd0 : data_mem[idx][20:0];
          fwd_v   = type_mem[idx] ? data_mem[idx] : 192'd0;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_type, fwd_addr};
  assign fwd_hit    = 1'b0;
  assign fwd_e      = '0;
  assign fwd_v      = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
//   Directed bench for writeback_unit (DEPTH = 4). Inputs change 1 time unit
//   after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_writeback_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_valid;
  logic         wb_ready;
  logic         wb_type;
  logic [2:0]   wb_dest;
  logic [20:0]  wb_scalar;
  logic [191:0] wb_vector;
  logic         rf_busy;
  logic         Reg_write;
  logic [2:0]   A3;
  logic         desType;
  logic [20:0]  wd3e;
  logic [191:0] wd3v;
  logic [5:0]   pend_e, pend_v;
  logic         bad_dest;
  logic         fwd_type;
  logic [2:0]   fwd_addr;
  logic         fwd_hit;
  logic [20:0]  fwd_e;
  logic [191:0] fwd_v;

  int checks = 0;
  int errors = 0;

  logic [191:0] vec_a;

  writeback_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_type(wb_type),
    .wb_dest(wb_dest), .wb_scalar(wb_scalar), .wb_vector(wb_vector),
    .rf_busy(rf_busy), .Reg_write(Reg_write), .A3(A3), .desType(desType),
    .wd3e(wd3e), .wd3v(wd3v), .pend_e(pend_e), .pend_v(pend_v),
    .bad_dest(bad_dest), .fwd_type(fwd_type), .fwd_addr(fwd_addr),
    .fwd_hit(fwd_hit), .fwd_e(fwd_e), .fwd_v(fwd_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic t, input logic [2:0] d,
                       input logic [20:0] s, input logic [191:0] vv);
    wb_valid  = v;
    wb_type   = t;
    wb_dest   = d;
    wb_scalar = s;
    wb_vector = vv;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 3'd0, 21'd0, 192'd0);
  endtask

  initial begin
    vec_a    = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_F00D_CAFE, 64'h1111_2222_3333_4444};
    rst      = 1'b1;
    rf_busy  = 1'b0;
    fwd_type = 1'b0;
    fwd_addr = 3'd0;
    idle_in();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", wb_ready, 1);
    check("rst_regwrite", Reg_write, 0);
    check("rst_pend_e", pend_e, 0);
    check("rst_pend_v", pend_v, 0);
    check("rst_bad_dest", bad_dest, 0);
    check("rst_fwd_hit", fwd_hit, 0);

    // Single scalar write, one-cycle latency
    drive(1'b1, 1'b0, 3'd3, 21'h1ABCD, 192'd0);
    tick();
    idle_in();
    check("s1_not_yet", Reg_write, 0);
    check("s1_pend_q", pend_e, 6'b001000);
    tick();
    check("s1_regwrite", Reg_write, 1);
    check("s1_a3", A3, 3);
    check("s1_type", desType, 0);
    check("s1_wd3e", wd3e, 21'h1ABCD);
    check("s1_wd3v", wd3v, 0);
    check("s1_pend_out", pend_e, 6'b001000);
    tick();
    check("s1_done", Reg_write, 0);
    check("s1_pend_clr", pend_e, 0);

    // Back-to-back pushes give back-to-back writes
    drive(1'b1, 1'b0, 3'd1, 21'h00011, 192'd0);
    tick();
    drive(1'b1, 1'b0, 3'd4, 21'h00044, 192'd0);
    tick();
    idle_in();
    check("bb_w0", Reg_write, 1);
    check("bb_a0", A3, 1);
    check("bb_d0", wd3e, 21'h00011);
    tick();
    check("bb_w1", Reg_write, 1);
    check("bb_a1", A3, 4);
    check("bb_d1", wd3e, 21'h00044);
    tick();
    check("bb_idle", Reg_write, 0);

    // Fill while stalled, attempt a push into the full FIFO, then drain
    rf_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 3'(i), 21'(32'h100 + i), 192'd0);
      tick();
      check("fill_stall", Reg_write, 0);
    end
    check("full_ready", wb_ready, 0);
    drive(1'b1, 1'b0, 3'd4, 21'h999, 192'd0);
    tick();
    idle_in();
    check("full_ready2", wb_ready, 0);
    check("full_pend", pend_e, 6'b001111);
    rf_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_w", Reg_write, 1);
      check("drain_a3", A3, 3'(i));
      check("drain_d", wd3e, 21'(32'h100 + i));
    end
    tick();
    check("drain_end", Reg_write, 0);
    check("drain_ready", wb_ready, 1);
    check("drain_pend", pend_e, 0);

    // Illegal destination is dropped with a one-cycle bad_dest pulse
    drive(1'b1, 1'b1, 3'd7, 21'd0, vec_a);
    tick();
    idle_in();
    check("bad_pulse", bad_dest, 1);
    check("bad_pend_v", pend_v, 0);
    check("bad_nowrite", Reg_write, 0);
    tick();
    check("bad_pulse_end", bad_dest, 0);
    check("bad_nowrite2", Reg_write, 0);

    // Vector and scalar to register 2 while stalled; forwarding lookups
    rf_busy = 1'b1;
    drive(1'b1, 1'b1, 3'd2, 21'd0, vec_a);
    tick();
    drive(1'b1, 1'b0, 3'd2, 21'h00055, 192'd0);
    tick();
    idle_in();
    check("dual_pend_v", pend_v, 6'b000100);
    check("dual_pend_e", pend_e, 6'b000100);
    fwd_type = 1'b1;
    fwd_addr = 3'd2;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd_v_hit", fwd_hit, 1);
    check("fwd_v_data", fwd_v, vec_a);
    check("fwd_v_e0", fwd_e, 0);
    fwd_type = 1'b0;
    #1;
    check("fwd_e_hit", fwd_hit, 1);
    check("fwd_e_data", fwd_e, 21'h00055);
    fwd_addr = 3'd5;
    #1;
    check("fwd_miss", fwd_hit, 0);
`else
    check("fwd_off_hit", fwd_hit, 0);
    check("fwd_off_v", fwd_v, 0);
    check("fwd_off_e", fwd_e, 0);
`endif
    fwd_type = 1'b1;
    fwd_addr = 3'd2;
    rf_busy  = 1'b0;
    tick();
    check("dual_w0", Reg_write, 1);
    check("dual_type0", desType, 1);
    check("dual_a0", A3, 2);
    check("dual_wd3v", wd3v, vec_a);
    check("dual_wd3e0", wd3e, 0);
    check("dual_pend_v_out", pend_v, 6'b000100);
`ifdef WB_FORWARD_EN
    check("fwd_out_hit", fwd_hit, 1);
    check("fwd_out_v", fwd_v, vec_a);
`endif
    tick();
    check("dual_w1", Reg_write, 1);
    check("dual_type1", desType, 0);
    check("dual_wd3e", wd3e, 21'h00055);
    check("dual_wd3v0", wd3v, 0);
    check("dual_pend_v_clr", pend_v, 0);
    tick();
    check("dual_idle", Reg_write, 0);
    check("dual_pend_e_clr", pend_e, 0);

    // Reset with three queued entries
    rf_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'(i + 3), 21'(32'h200 + i), 192'd0);
      tick();
    end
    idle_in();
    check("pre_rst_pend", pend_e, 6'b111000);
    rf_busy = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_w", Reg_write, 0);
    check("mrst_pend_e", pend_e, 0);
    check("mrst_pend_v", pend_v, 0);
    check("mrst_ready", wb_ready, 1);
    check("mrst_a3", A3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_nowrite", Reg_write, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
